// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and serial line levels for the UART TX path
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
   localparam logic UART_IDLE  = 1'b1;
   localparam logic UART_START = 1'b0;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: reloadable down-counter producing one tick in the last cycle of each bit
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   assign tick = cnt_q == '0;
   // reload at every bit boundary so the period never drifts; otherwise count down to zero and hold
   always_comb cnt_d = load ? div : (tick ? cnt_q : cnt_q - 1'b1);
   // counter register
   always_ff @(posedge Clk) begin
      if (!Rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_fifo_tx_reader.sv
// uart_fifo_tx_reader: pops TX FIFO words while the line is idle and serializes them LSB-first
module uart_fifo_tx_reader
   import uart_pkg::*;
#(
   parameter int width = 8,
   parameter int DIV_W = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             EF,
   input  logic [width-1:0] DO,
   input  logic             WE,
   output logic             RE,
   input  logic [DIV_W-1:0] Div,
   input  logic             Par_En,
   input  logic             Par_Odd,
   input  logic             Stop2,
   output logic             TxD,
   output logic             Busy,
   output logic             Done
);
   localparam int BW = $clog2(width + 4);
   tx_state_t state_q, state_d;
   logic [width-1:0] sh_q, sh_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [DIV_W-1:0] div_q;
   logic par_en_q, par_q, stop2_q, tick, bt;
   assign RE   = Rst_n & (state_q == IDLE) & ~EF & ~WE;
   assign Busy = state_q != IDLE;
   assign bt   = tick & Busy;
   assign Done = bt & (state_q == STOP) & (bit_q == BW'(stop2_q));
   assign TxD  = state_q == START  ? UART_START :
                 state_q == DATA   ? sh_q[0]    :
                 state_q == PARITY ? par_q      : UART_IDLE;
   // the pop edge loads the live divisor; later bit boundaries use the frame's latched copy
   uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .load (RE | bt),
      .div  (RE ? Div : div_q),
      .tick (tick)
   );
   // frame sequencing: advance one phase or one bit per baud tick
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      if (RE) begin
         state_d = START;
         sh_d    = DO;
         bit_d   = '0;
      end else if (bt) begin
         case (state_q)
            START:  state_d = DATA;
            DATA: begin
               sh_d  = sh_q >> 1;
               bit_d = bit_q + 1'b1;
               if (bit_q == BW'(width - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
                  bit_d   = '0;
               end
            end
            PARITY: state_d = STOP;
            STOP: begin
               bit_d = bit_q + 1'b1;
               if (Done) begin
                  state_d = IDLE;
                  bit_d   = '0;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end
   // state, shifter and per-frame settings; settings are captured only at the pop edge
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         sh_q     <= '0;
         bit_q    <= '0;
         div_q    <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop2_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         if (RE) begin
            div_q    <= Div;
            par_en_q <= Par_En;
            par_q    <= ^DO ^ Par_Odd;
            stop2_q  <= Stop2;
         end
      end
   end
endmodule

// File: tb/tb_uart_fifo_tx_reader.sv
// tb_uart_fifo_tx_reader: waveform-queue model of the UART reader plus directed literal checks
module tb_uart_fifo_tx_reader;
   logic Clk, Rst_n, WE, Par_En, Par_Odd, Stop2;
   logic EF, RE, TxD, Busy, Done;
   logic [7:0] DO;
   logic [15:0] Div;
   logic [7:0] mem [16];
   int wr_ptr, rd_ptr, cyc, total, bad, c, c2, n0;
   bit cmp_en;
   logic [1:0] wq[$];
   int re_log[$], done_log[$];
   logic txd_at [4096];
   logic busy_at [4096];
   logic [9:0] pat;

   uart_fifo_tx_reader #(.width(8), .DIV_W(16)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .EF(EF), .DO(DO), .WE(WE), .RE(RE), .Div(Div),
      .Par_En(Par_En), .Par_Odd(Par_Odd), .Stop2(Stop2), .TxD(TxD), .Busy(Busy), .Done(Done)
   );

   assign EF = wr_ptr == rd_ptr;
   assign DO = mem[rd_ptr[3:0]];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // expected line waveform for one frame: one entry {done,txd} per clock cycle
   task automatic build(input logic [7:0] w);
      logic fb [12];
      int n;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[i+1] = w[i];
      n = 9;
      if (Par_En) begin fb[n] = ^w ^ Par_Odd; n++; end
      fb[n] = 1'b1; n++;
      if (Stop2) begin fb[n] = 1'b1; n++; end
      for (int b = 0; b < n; b++)
         for (int k = 0; k <= int'(Div); k++)
            wq.push_back({(b == n - 1) && (k == int'(Div)), fb[b]});
   endtask

   always @(posedge Clk) begin
      cyc = cyc + 1;
      if (!Rst_n) wq.delete();
      else if (wq.size() != 0) void'(wq.pop_front());
      else if (!EF && !WE) begin
         build(DO);
         rd_ptr <= rd_ptr + 1;
      end
   end

   always @(negedge Clk) begin
      if (cyc < 4096) begin
         txd_at[cyc] = TxD;
         busy_at[cyc] = Busy;
      end
      if (RE) re_log.push_back(cyc);
      if (Done) done_log.push_back(cyc);
      if (cmp_en) begin
         chk("re", RE, Rst_n && wq.size() == 0 && !EF && !WE);
         chk("busy", Busy, wq.size() != 0);
         chk("txd", TxD, wq.size() != 0 ? wq[0][0] : 1'b1);
         chk("done", Done, wq.size() != 0 ? wq[0][1] : 1'b0);
         chk("we_and_re", WE & RE, 0);
         chk("ef_and_re", EF & RE, 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic push(input logic [7:0] w);
      mem[wr_ptr[3:0]] = w;
      wr_ptr++;
   endtask

   task automatic wait_re(input int n, output int cr);
      cr = 0;
      for (int i = 0; i < 20 && re_log.size() <= n; i++) step(1);
      chk("re_seen", re_log.size() > n, 1);
      if (re_log.size() > n) cr = re_log[n];
   endtask

   function automatic int first_done(input int after);
      foreach (done_log[i]) if (done_log[i] > after) return done_log[i];
      return -1;
   endfunction

   function automatic int busy_cnt(input int a, input int b);
      int s = 0;
      for (int i = a; i <= b && i < 4096; i++) s += int'(busy_at[i]);
      return s;
   endfunction

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0; cyc = 0; wr_ptr = 0; rd_ptr = 0; cmp_en = 0;
      Rst_n = 1'b0; WE = 1'b0; Div = 16'd3; Par_En = 1'b0; Par_Odd = 1'b0; Stop2 = 1'b0;
      step(2);
      cmp_en = 1;
      chk("rst_txd", TxD, 1);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_re", RE, 0);
      Rst_n = 1'b1;
      step(2);
      // single 8N1 frame, 4 cycles per bit
      n0 = re_log.size();
      push(8'hA5);
      step(50);
      chk("t1_re_count", re_log.size() - n0, 1);
      c = re_log.size() > n0 ? re_log[n0] : 0;
      pat = 10'b1101001010;
      for (int i = 0; i < 10; i++) chk($sformatf("t1_bit%0d", i), txd_at[c + i * 4 + 2], pat[i]);
      chk("t1_done_at", first_done(c), c + 40);
      chk("t1_busy_len", busy_cnt(c + 1, c + 50), 40);
      // parity even then odd on 8'h07
      Par_En = 1'b1;
      n0 = re_log.size();
      push(8'h07);
      step(55);
      c = re_log.size() > n0 ? re_log[n0] : 0;
      chk("t2_even_par", txd_at[c + 38], 1);
      chk("t2_done_at", first_done(c), c + 44);
      Par_Odd = 1'b1;
      n0 = re_log.size();
      push(8'h07);
      step(55);
      c = re_log.size() > n0 ? re_log[n0] : 0;
      chk("t2_odd_par", txd_at[c + 38], 0);
      // three queued words back-to-back at 1 cycle per bit
      Par_En = 1'b0; Par_Odd = 1'b0; Div = 16'd0;
      n0 = re_log.size();
      push(8'h3C); push(8'h81); push(8'hFF);
      step(45);
      chk("t3_re_count", re_log.size() - n0, 3);
      if (re_log.size() >= n0 + 3) begin
         c = re_log[n0];
         chk("t3_gap1", re_log[n0+1] - re_log[n0], 11);
         chk("t3_gap2", re_log[n0+2] - re_log[n0+1], 11);
         chk("t3_idle_txd", txd_at[c + 11], 1);
         chk("t3_idle_busy", busy_at[c + 11], 0);
      end
      chk("t3_ef_after", EF, 1);
      // writer holding WE defers the pop
      WE = 1'b1;
      push(8'h55);
      n0 = re_log.size();
      step(5);
      chk("t4_no_re_under_we", re_log.size() - n0, 0);
      WE = 1'b0;
      @(negedge Clk);
      chk("t4_re_release", RE, 1);
      step(15);
      // reset during DATA bit 3 aborts the frame
      Div = 16'd1;
      n0 = re_log.size();
      push(8'h5A);
      wait_re(n0, c);
      while (cyc < c + 9) step(1);
      Rst_n = 1'b0;
      @(negedge Clk);
      chk("t5_re_in_reset", RE, 0);
      step(1);
      Rst_n = 1'b1;
      chk("t5_txd_after", TxD, 1);
      chk("t5_busy_after", Busy, 0);
      n0 = re_log.size();
      push(8'hC3);
      wait_re(n0, c2);
      step(3);
      chk("t5_start_a", txd_at[c2 + 1], 0);
      chk("t5_start_b", txd_at[c2 + 2], 0);
      step(25);
      chk("t5_one_pop", re_log.size() - n0, 1);
      // two stop bits, divisor changed mid-frame
      Stop2 = 1'b1;
      n0 = re_log.size();
      push(8'h96);
      wait_re(n0, c);
      step(4);
      Div = 16'd7;
      step(30);
      chk("t6_done_at", first_done(c), c + 22);
      chk("t6_busy_len", busy_cnt(c + 1, c + 34), 22);
      chk("t6_stop_first", txd_at[c + 19], 1);
      chk("t6_stop_last", txd_at[c + 22], 1);
      Div = 16'd1; Stop2 = 1'b0;
      step(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
